// File: rtl/mem_image_loader_pkg.sv
// Shared constants, word-width codes and FSM state type for the memory image loader.
// Build option: MEM_IMAGE_LOADER_CHECKSUM_EN adds the trailing checksum state.
package mem_image_loader_pkg;

  // Word-width codes: W = 1 << (code + 4)
  localparam int unsigned XLEN_32B = 1;
  localparam int unsigned XLEN_64B = 2;

  localparam logic [7:0]  LDR_SYNC = 8'hA5;
  localparam int unsigned HDR_LEN  = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HDR_ADDR = 3'd1,
    HDR_CNT  = 3'd2,
    DATA     = 3'd3,
`ifdef MEM_IMAGE_LOADER_CHECKSUM_EN
    CSUM     = 3'd4,
`endif
    DONE     = 3'd5,
    ERR      = 3'd6
  } ldr_state_t;

  // Word width in bits for a width code
  function automatic int unsigned word_bits(input int unsigned xlen);
    return (xlen == XLEN_64B) ? 32'd64 : 32'd32;
  endfunction

endpackage

// File: rtl/mem_image_loader_if.sv
// Host byte stream and memory write port of the image loader.
interface mem_image_loader_if #(
  parameter int unsigned W      = 32,
  parameter int unsigned ADDR_W = 32
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [W-1:0]      mem_wdata;

  // Host side: drives bytes, observes the write port
  modport master (
    output byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );

  // Loader side
  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_image_loader_byte_word_packer.sv
// Little-endian byte-to-word packer: emits the assembled word combinationally
// together with word_valid_c on the cycle its last byte is taken.
module mem_image_loader_byte_word_packer #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         take,
  input  logic [7:0]   data,
  output logic [W-1:0] word_c,
  output logic         word_valid_c
);
  localparam int unsigned B  = W / 8;
  localparam int unsigned CW = $clog2(B);

  logic [W-9:0] shreg;
  logic [CW-1:0] cnt;

  assign word_c       = {data, shreg};
  assign word_valid_c = take && (cnt == CW'(B - 1));

  // Shift bytes in from the top so the first byte ends up in the lowest lane
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (take) begin
      shreg <= {data, shreg[W-9:8]};
      cnt   <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/mem_image_loader.sv
// Framed byte-stream image loader: SYNC, ADDR(4 LE), COUNT(4 LE words), data,
// optional checksum. Writes words to memory and holds the core in reset until done.
// Build option: MEM_IMAGE_LOADER_CHECKSUM_EN enables the trailing checksum byte.
module mem_image_loader
  import mem_image_loader_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_32B,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  mem_image_loader_if.slave   bus,
  output logic                core_rst,
  output logic                busy,
  output logic                done,
  output logic                err
);
  localparam int unsigned W   = word_bits(XLEN);
  localparam int unsigned B   = W / 8;
  localparam int unsigned BW  = $clog2(B);
  localparam int unsigned HW  = 8 * HDR_LEN;
  localparam int unsigned HIW = $clog2(HDR_LEN);

`ifdef MEM_IMAGE_LOADER_CHECKSUM_EN
  localparam ldr_state_t AFTER_DATA = CSUM;
`else
  localparam ldr_state_t AFTER_DATA = DONE;
`endif

  ldr_state_t state, state_next;

  logic           take_c;
  logic           pack_take_c;
  logic           frame_start_c;
  logic           hdr_last_c;
  logic           last_word_c;
  logic           in_frame_c;
  logic [HW-1:0]  hdr_shift_c;
  logic [W-1:0]   word_c;
  logic           word_valid_c;

  logic [HIW-1:0]    hdr_idx;
  logic [HW-1:0]     hdr_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [HW-1:0]     words_left;
`ifdef MEM_IMAGE_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q;
`endif

  assign take_c      = bus.byte_valid && bus.byte_ready;
  assign pack_take_c = take_c && (state == DATA);
  assign hdr_shift_c = {bus.byte_data, hdr_q[HW-1:8]};

  mem_image_loader_byte_word_packer #(.W(W)) u_packer (
    .clk          (clk),
    .rst          (rst),
    .clear        (frame_start_c),
    .take         (pack_take_c),
    .data         (bus.byte_data),
    .word_c       (word_c),
    .word_valid_c (word_valid_c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and frame control decode
  always_comb begin
    state_next    = state;
    frame_start_c = 1'b0;
    in_frame_c    = 1'b0;
    hdr_last_c    = take_c && (hdr_idx == HIW'(HDR_LEN - 1));
    last_word_c   = word_valid_c && (words_left == HW'(1));
    case (state)
      IDLE, DONE, ERR: begin
        if (take_c && (bus.byte_data == LDR_SYNC)) begin
          frame_start_c = 1'b1;
          state_next    = HDR_ADDR;
        end
      end
      HDR_ADDR: begin
        in_frame_c = 1'b1;
        if (hdr_last_c)
          state_next = (hdr_shift_c[BW-1:0] != '0) ? ERR : HDR_CNT;
      end
      HDR_CNT: begin
        in_frame_c = 1'b1;
        if (hdr_last_c)
          state_next = (hdr_shift_c == '0) ? AFTER_DATA : DATA;
      end
      DATA: begin
        in_frame_c = 1'b1;
        if (last_word_c) state_next = AFTER_DATA;
      end
`ifdef MEM_IMAGE_LOADER_CHECKSUM_EN
      CSUM: begin
        in_frame_c = 1'b1;
        if (take_c) state_next = (bus.byte_data == csum_q) ? DONE : ERR;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // Header capture, address/word bookkeeping, memory write port and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.byte_ready <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      core_rst       <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      hdr_idx        <= '0;
      hdr_q          <= '0;
      waddr_q        <= '0;
      words_left     <= '0;
    end else begin
      bus.byte_ready <= 1'b1;
      bus.mem_we     <= 1'b0;
      // Status follows the state one cycle later, so DONE shows after the final strobe
      busy           <= in_frame_c;
      done           <= (state == DONE);
      err            <= (state == ERR);
      core_rst       <= (state != DONE);
      if (frame_start_c) begin
        hdr_idx <= '0;
      end else if (take_c && ((state == HDR_ADDR) || (state == HDR_CNT))) begin
        hdr_q   <= hdr_shift_c;
        hdr_idx <= hdr_idx + HIW'(1);
        if (hdr_last_c && (state == HDR_ADDR)) waddr_q    <= ADDR_W'(hdr_shift_c);
        if (hdr_last_c && (state == HDR_CNT))  words_left <= hdr_shift_c;
      end
      if (word_valid_c) begin
        bus.mem_we    <= 1'b1;
        bus.mem_addr  <= waddr_q;
        bus.mem_wdata <= word_c;
        waddr_q       <= waddr_q + ADDR_W'(B);
        words_left    <= words_left - HW'(1);
      end
    end
  end

`ifdef MEM_IMAGE_LOADER_CHECKSUM_EN
  // Running 8-bit sum of data bytes
  always_ff @(posedge clk) begin
    if (rst || frame_start_c) csum_q <= 8'h00;
    else if (pack_take_c)     csum_q <= csum_q + bus.byte_data;
  end
`endif

endmodule

// File: tb/tb_mem_image_loader.sv
// Directed and randomized frames against a frame-level reference model.
module tb_mem_image_loader;
  import mem_image_loader_pkg::*;

  typedef logic [63:0] wr_t;  // {addr, data}

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic core_rst, busy, done, err;

  int errors = 0;
  int checks = 0;

  logic [7:0] dbytes[$];
  wr_t        obs_q[$];
  int         cyc = 0;
  int         last_we = -1;
  int         done_rise = -1;
  logic       prev_done = 1'b0;

  mem_image_loader_if #(.W(32), .ADDR_W(32)) bus ();

  mem_image_loader #(.XLEN(XLEN_32B), .ADDR_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .core_rst (core_rst),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Write-port monitor
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bus.mem_we === 1'b1) begin
      obs_q.push_back({bus.mem_addr, bus.mem_wdata});
      last_we = cyc;
    end
    if (done === 1'b1 && prev_done !== 1'b1) done_rise = cyc;
    prev_done = done;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Present one byte at a negedge; accepted at the following posedge
  task automatic send_byte(input logic [7:0] b);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.byte_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic fill_data(input int nbytes);
    dbytes.delete();
    for (int i = 0; i < nbytes; i++) dbytes.push_back(8'($urandom()));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".ready"},    64'(bus.byte_ready), 64'd0);
    check({tag, ".we"},       64'(bus.mem_we),     64'd0);
    check({tag, ".addr"},     64'(bus.mem_addr),   64'd0);
    check({tag, ".wdata"},    64'(bus.mem_wdata),  64'd0);
    check({tag, ".core_rst"}, 64'(core_rst),       64'd1);
    check({tag, ".busy"},     64'(busy),           64'd0);
    check({tag, ".done"},     64'(done),           64'd0);
    check({tag, ".err"},      64'(err),            64'd0);
  endtask

  // Send a whole frame from dbytes and compare against the frame-level model
  task automatic run_frame(input logic [31:0] addr, input int cnt, input bit csum_bad,
                           input bit gaps, input string tag);
    wr_t         exp_q[$];
    logic [7:0]  sum;
    logic [31:0] c32;
    bit          exp_err;
    int          n;
    sum     = 8'h00;
    c32     = 32'(cnt);
    exp_err = (addr[1:0] != 2'b00);
    if (!exp_err) begin
      for (int k = 0; k < cnt; k++) begin
        exp_q.push_back({addr + 32'(4 * k),
                         dbytes[4*k+3], dbytes[4*k+2], dbytes[4*k+1], dbytes[4*k]});
        for (int j = 0; j < 4; j++) sum = sum + dbytes[4*k+j];
      end
    end
`ifdef MEM_IMAGE_LOADER_CHECKSUM_EN
    if (csum_bad) exp_err = 1'b1;
`endif
    obs_q.delete();
    done_rise = -1;
    last_we   = -1;
    check({tag, ".ready"}, 64'(bus.byte_ready), 64'd1);
    send_byte(LDR_SYNC);
    for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
    if (addr[1:0] == 2'b00) begin
      for (int i = 0; i < 4; i++) send_byte(c32[8*i +: 8]);
      for (int i = 0; i < 4 * cnt; i++) begin
        if (gaps && ($urandom_range(0, 3) == 0)) idle($urandom_range(1, 2));
        send_byte(dbytes[i]);
      end
`ifdef MEM_IMAGE_LOADER_CHECKSUM_EN
      send_byte(csum_bad ? sum + 8'h01 : sum);
`endif
    end
    bus.byte_valid = 1'b0;
    n = 0;
    while (!(done === 1'b1 || err === 1'b1) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".finished"}, 64'(n < 40), 64'd1);
    @(negedge clk);
    check({tag, ".done"},     64'(done),     64'(!exp_err));
    check({tag, ".err"},      64'(err),      64'(exp_err));
    check({tag, ".core_rst"}, 64'(core_rst), 64'(exp_err));
    check({tag, ".busy"},     64'(busy),     64'd0);
    check({tag, ".nwrites"},  64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("%s.wr%0d", tag, i), obs_q[i], exp_q[i]);
`ifndef MEM_IMAGE_LOADER_CHECKSUM_EN
    if (!exp_err && cnt > 0)
      check({tag, ".done_timing"}, 64'(done_rise), 64'(last_we + 1));
`endif
  endtask

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 64'(bus.byte_ready), 64'd1);

    // Two instruction words at 0x100
    dbytes = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    run_frame(32'h0000_0100, 2, 1'b0, 1'b0, "t1");
    check("t1.word0", obs_q.size() > 0 ? obs_q[0] : 64'hx, {32'h0000_0100, 32'h0000_0513});
    check("t1.word1", obs_q.size() > 1 ? obs_q[1] : 64'hx, {32'h0000_0104, 32'h0010_0593});

    // Misaligned address, then a good frame clears the error
    run_frame(32'h0000_0102, 0, 1'b0, 1'b0, "t2_misaligned");
    fill_data(8);
    run_frame(32'h0000_2000, 2, 1'b0, 1'b0, "t2_recover");

    // Empty image
    run_frame(32'h0000_0040, 0, 1'b0, 1'b0, "t3_count0");

    // Address wraps past the top of memory
    fill_data(8);
    run_frame(32'hFFFF_FFFC, 2, 1'b0, 1'b1, "t4_wrap");

`ifdef MEM_IMAGE_LOADER_CHECKSUM_EN
    dbytes = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    run_frame(32'h0000_0100, 2, 1'b1, 1'b0, "t5_bad_csum");
`endif

    // Reset in the middle of the first data word
    obs_q.delete();
    send_byte(LDR_SYNC);
    send_byte(8'h00); send_byte(8'h02); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h03); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22);
    bus.byte_valid = 1'b0;
    check("t6.busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("t6.reset");
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      logic [7:0] b;
      b = 8'($urandom());
      if (b == LDR_SYNC) b = 8'h00;
      send_byte(b);
    end
    idle(4);
    check("t6.nwrites", 64'(obs_q.size()), 64'd0);
    check("t6.busy",    64'(busy),     64'd0);
    check("t6.done",    64'(done),     64'd0);
    check("t6.core_rst",64'(core_rst), 64'd1);
    fill_data(12);
    run_frame(32'h0000_0300, 3, 1'b0, 1'b1, "t6_after");

    // Randomized frames
    for (int f = 0; f < 8; f++) begin
      logic [31:0] a;
      int          c;
      a = $urandom() & 32'hFFFF_FFFC;
      if (f == 0) a = 32'hFFFF_FFF8;
      c = $urandom_range(1, 4);
      fill_data(4 * c);
      run_frame(a, c, 1'($urandom_range(0, 1)), 1'b1, $sformatf("rand%0d", f));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
